// File: rtl/uart_ctrl_pkg.sv
// Shared constants for the Art32 UART bus front end: register map, bit positions
// and the line timing used to decide when the transmitter has gone idle.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA     = 2'd0,
        ADDR_STATUS   = 2'd1,
        ADDR_CONTROL  = 2'd2,
        ADDR_RESERVED = 2'd3
    } reg_addr_e;

    localparam int ST_RX_VALID    = 0;
    localparam int ST_RX_FULL     = 1;
    localparam int ST_TX_EMPTY    = 2;
    localparam int ST_TX_FULL     = 3;
    localparam int ST_RX_OVERFLOW = 4;
    localparam int ST_TX_OVERFLOW = 5;
    localparam int ST_TX_IDLE     = 6;

    localparam int CTRL_RX_IRQ_EN = 0;
    localparam int CTRL_TX_IRQ_EN = 1;

    // One frame is start + 8 data + stop + one guard bit at 40 MHz / 115200 baud.
    localparam int BIT_CLKS      = 347;
    localparam int FRAME_BITS    = 11;
    localparam int FETCH_TO_IDLE = BIT_CLKS * FRAME_BITS;
    localparam int IDLE_CNT_W    = $clog2(FETCH_TO_IDLE + 1);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO; pointers carry one extra wrap bit
// so full and empty are distinguished without a separate count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_controller.sv
// Memory-mapped front end for the Art32 UART: TX/RX byte FIFOs, status and
// control registers, sticky overflow flags and a level interrupt.
module uart_controller
    import uart_ctrl_pkg::*;
#(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  bus_addr,
    input  logic        bus_wr,
    input  logic        bus_rd,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        irq,
    output logic [7:0]  uart_data_in,
    output logic        uart_transmit,
    input  logic        uart_fetch,
    input  logic [7:0]  uart_data_out,
    input  logic        uart_received
);

    logic                  wr_data, rd_data, wr_status, wr_control;
    logic                  tx_empty, tx_full, rx_empty, rx_full;
    logic [7:0]            rx_head;
    logic                  fetch_ok, tx_idle;
    logic [31:0]           status;
    logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic                  rx_ovf_q, rx_ovf_d;
    logic                  tx_ovf_q, tx_ovf_d;
    logic [1:0]            ctrl_q, ctrl_d;
    logic [31:0]           bus_rdata_q, bus_rdata_d;
    logic                  irq_q, irq_d;

    assign wr_data    = bus_wr && (bus_addr == ADDR_DATA);
    assign rd_data    = bus_rd && (bus_addr == ADDR_DATA);
    assign wr_status  = bus_wr && (bus_addr == ADDR_STATUS);
    assign wr_control = bus_wr && (bus_addr == ADDR_CONTROL);

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_data),
        .pop   (uart_fetch),
        .din   (bus_wdata[7:0]),
        .dout  (uart_data_in),
        .empty (tx_empty),
        .full  (tx_full)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (uart_received),
        .pop   (rd_data),
        .din   (uart_data_out),
        .dout  (rx_head),
        .empty (rx_empty),
        .full  (rx_full)
    );

    assign uart_transmit = ~tx_empty;
    assign fetch_ok      = uart_fetch & ~tx_empty;
    assign tx_idle       = tx_empty && (idle_cnt_q == '0);

    always_comb begin
        status                 = '0;
        status[ST_RX_VALID]    = ~rx_empty;
        status[ST_RX_FULL]     = rx_full;
        status[ST_TX_EMPTY]    = tx_empty;
        status[ST_TX_FULL]     = tx_full;
        status[ST_RX_OVERFLOW] = rx_ovf_q;
        status[ST_TX_OVERFLOW] = tx_ovf_q;
        status[ST_TX_IDLE]     = tx_idle;
    end

    // The idle countdown restarts on every fetch, so tx_idle tracks the last byte handed over.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (fetch_ok) begin
            idle_cnt_d = IDLE_CNT_W'(FETCH_TO_IDLE);
        end else if (idle_cnt_q != '0) begin
            idle_cnt_d = idle_cnt_q - IDLE_CNT_W'(1);
        end

        rx_ovf_d = rx_ovf_q;
        tx_ovf_d = tx_ovf_q;
        if (wr_status && bus_wdata[ST_RX_OVERFLOW]) rx_ovf_d = 1'b0;
        if (wr_status && bus_wdata[ST_TX_OVERFLOW]) tx_ovf_d = 1'b0;
        if (uart_received && rx_full && !rd_data)   rx_ovf_d = 1'b1;
        if (wr_data && tx_full && !uart_fetch)      tx_ovf_d = 1'b1;

        ctrl_d = ctrl_q;
        if (wr_control) ctrl_d = bus_wdata[1:0];

        bus_rdata_d = bus_rdata_q;
        if (bus_rd) begin
            case (reg_addr_e'(bus_addr))
                ADDR_DATA:    bus_rdata_d = {24'h0, rx_empty ? 8'h00 : rx_head};
                ADDR_STATUS:  bus_rdata_d = status;
                ADDR_CONTROL: bus_rdata_d = {30'h0, ctrl_q};
                default:      bus_rdata_d = '0;
            endcase
        end

        irq_d = (ctrl_q[CTRL_RX_IRQ_EN] & ~rx_empty) | (ctrl_q[CTRL_TX_IRQ_EN] & tx_empty)
              | rx_ovf_q | tx_ovf_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt_q  <= '0;
            rx_ovf_q    <= 1'b0;
            tx_ovf_q    <= 1'b0;
            ctrl_q      <= '0;
            bus_rdata_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            idle_cnt_q  <= idle_cnt_d;
            rx_ovf_q    <= rx_ovf_d;
            tx_ovf_q    <= tx_ovf_d;
            ctrl_q      <= ctrl_d;
            bus_rdata_q <= bus_rdata_d;
            irq_q       <= irq_d;
        end
    end

    assign bus_rdata = bus_rdata_q;
    assign irq       = irq_q;

endmodule
